// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch target predictor: mode encoding,
// checkpoint record and counter reset value.
package bp_pkg;

    // Checkpoint fields are sized for the largest supported configuration.
    localparam int unsigned MAX_WORD = 64;
    localparam int unsigned MAX_IDX  = 8;
    localparam int unsigned MAX_HIST = 8;

    typedef enum logic {
        BIMODAL = 1'b0,
        GSHARE  = 1'b1
    } bp_mode_e;

    typedef struct packed {
        logic [MAX_WORD-1:0] pc_next;
        logic                taken;
        logic [MAX_IDX-1:0]  idx;
        logic [MAX_HIST-1:0] ghr;
    } checkpoint_t;

    // Weakly not-taken value for a counter of the given width.
    function automatic int unsigned cnt_init(int unsigned bits);
        return (1 << (bits - 1)) - 1;
    endfunction

    function automatic bp_mode_e mode_of(int unsigned hist_bits);
        return (hist_bits == 0) ? BIMODAL : GSHARE;
    endfunction

endpackage

// File: rtl/branch_target_predictor_sat_counter.sv
// Saturating up/down counter with enable and asynchronous reset to INIT.
module sat_counter
    import bp_pkg::*;
#(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned INIT  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (enable && inc && !dec && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end else if (enable && dec && !inc && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= WIDTH'(INIT);
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB plus bimodal/gshare pattern history table with a single
// checkpoint for the in-flight branch and speculative global history.
module branch_target_predictor
    import bp_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned ENTRIES   = 16,
    parameter int unsigned CNT_BITS  = 2,
    parameter int unsigned HIST_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] lk_pc,
    input  logic                 lk_is_branch,
    input  logic                 lk_fire,
    output logic                 lk_taken,
    output logic                 lk_hit,
    output logic [WORD_SIZE-1:0] lk_next_pc,
    input  logic                 up_valid,
    input  logic [WORD_SIZE-1:0] up_pc,
    input  logic                 up_taken,
    input  logic [WORD_SIZE-1:0] up_target,
    output logic                 up_mispredict,
    output logic [WORD_SIZE-1:0] up_fix_pc,
    output logic [15:0]          stat_branches,
    output logic [15:0]          stat_mispred
);

    localparam int unsigned IDX   = $clog2(ENTRIES);
    localparam int unsigned TAG_W = WORD_SIZE - IDX;
    localparam int unsigned GW    = (HIST_BITS > 0) ? HIST_BITS : 1;
    localparam bp_mode_e    MODE  = mode_of(HIST_BITS);

    logic                 btb_valid_q [ENTRIES];
    logic [TAG_W-1:0]     btb_tag_q   [ENTRIES];
    logic [WORD_SIZE-1:0] btb_tgt_q   [ENTRIES];
    logic [CNT_BITS-1:0]  pht         [ENTRIES];

    logic [GW-1:0]        ghr_q, ghr_d;
    checkpoint_t          cp_q, cp_d, cp_chk;

    logic [IDX-1:0]       lk_bidx, lk_idx, ghr_ext, cp_idx, up_bidx;
    logic [WORD_SIZE-1:0] lk_pc_inc, cp_pc_next;
    logic [GW-1:0]        cp_ghr;
    logic                 lk_push, pht_we;

    // Lookup
    assign lk_bidx   = lk_pc[IDX-1:0];
    assign ghr_ext   = (MODE == GSHARE) ? IDX'(ghr_q) : '0;
    assign lk_idx    = lk_bidx ^ ghr_ext;
    assign lk_pc_inc = lk_pc + WORD_SIZE'(1);

    assign lk_hit     = !reset && btb_valid_q[lk_bidx] &&
                        (btb_tag_q[lk_bidx] == lk_pc[WORD_SIZE-1:IDX]);
    assign lk_taken   = lk_is_branch && lk_hit && pht[lk_idx][CNT_BITS-1];
    assign lk_next_pc = lk_taken ? btb_tgt_q[lk_bidx] : lk_pc_inc;
    assign lk_push    = !reset && lk_fire && lk_is_branch;

    // Resolution against the checkpointed prediction
    assign cp_pc_next    = cp_q.pc_next[WORD_SIZE-1:0];
    assign cp_idx        = cp_q.idx[IDX-1:0];
    assign cp_ghr        = cp_q.ghr[GW-1:0];
    assign up_bidx       = up_pc[IDX-1:0];
    assign up_mispredict = !reset && up_valid && (up_taken != cp_q.taken);
    assign up_fix_pc     = up_taken ? up_target : cp_pc_next;
    assign pht_we        = !reset && up_valid;

    always_comb begin
        cp_d = cp_q;
        if (lk_push) begin
            cp_d         = '0;
            cp_d.pc_next = MAX_WORD'(lk_pc_inc);
            cp_d.taken   = lk_taken;
            cp_d.idx     = MAX_IDX'(lk_idx);
            cp_d.ghr     = MAX_HIST'(ghr_q);
        end
    end

    // History repair wins over the wrong-path speculative shift.
    always_comb begin
        ghr_d = ghr_q;
        if (MODE == GSHARE) begin
            if (up_mispredict) begin
                ghr_d = (cp_ghr << 1) | GW'(up_taken);
            end else if (lk_push) begin
                ghr_d = (ghr_q << 1) | GW'(lk_taken);
            end
        end
    end

    // Checkpoint bits above the configured widths stay zero.
    always_comb begin
        cp_chk         = '0;
        cp_chk.pc_next = MAX_WORD'(cp_pc_next);
        cp_chk.taken   = cp_q.taken;
        cp_chk.idx     = MAX_IDX'(cp_idx);
        cp_chk.ghr     = MAX_HIST'(cp_ghr);
        assert (cp_q == cp_chk);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr_q <= '0;
            cp_q  <= '0;
        end else begin
            ghr_q <= ghr_d;
            cp_q  <= cp_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid_q[i] <= 1'b0;
                btb_tag_q[i]   <= '0;
                btb_tgt_q[i]   <= '0;
            end
        end else if (up_valid && up_taken) begin
            btb_valid_q[up_bidx] <= 1'b1;
            btb_tag_q[up_bidx]   <= up_pc[WORD_SIZE-1:IDX];
            btb_tgt_q[up_bidx]   <= up_target;
        end
    end

    for (genvar i = 0; i < ENTRIES; i++) begin : g_pht
        sat_counter #(
            .WIDTH(CNT_BITS),
            .INIT (cnt_init(CNT_BITS))
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .enable(pht_we && (cp_idx == IDX'(i))),
            .inc   (up_taken),
            .dec   (!up_taken),
            .count (pht[i])
        );
    end

    sat_counter #(
        .WIDTH(16),
        .INIT (0)
    ) u_stat_branches (
        .clk   (clk),
        .reset (reset),
        .enable(pht_we),
        .inc   (1'b1),
        .dec   (1'b0),
        .count (stat_branches)
    );

    sat_counter #(
        .WIDTH(16),
        .INIT (0)
    ) u_stat_mispred (
        .clk   (clk),
        .reset (reset),
        .enable(up_mispredict),
        .inc   (1'b1),
        .dec   (1'b0),
        .count (stat_mispred)
    );

endmodule

// File: doc/branch_target_predictor.md
BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

Interface
REQ-001 Parameters, one per line:
- WORD_SIZE, 16, PC/target width.
- ENTRIES, 16, BTB/PHT depth; power of two, 4..256; IDX = log2(ENTRIES).
- CNT_BITS, 2, saturating-counter width, 1..4.
- HIST_BITS, 4, global-history length, 0..IDX; 0 selects bimodal mode, otherwise gshare.

REQ-002 Ports, one per line:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- lk_pc  in  WORD_SIZE  fetch PC.
- lk_is_branch  in  1  fetched word is a conditional branch.
- lk_fire  in  1  IF stage advances this cycle (not stalled).
- lk_taken  out  1  predicted taken.
- lk_hit  out  1  BTB tag hit.
- lk_next_pc  out  WORD_SIZE  predicted next fetch PC.
- up_valid  in  1  branch resolved in ID this cycle.
- up_pc  in  WORD_SIZE  resolved branch PC.
- up_taken  in  1  actual outcome.
- up_target  in  WORD_SIZE  computed target.
- up_mispredict  out  1  resolution disagrees with checkpointed prediction.
- up_fix_pc  out  WORD_SIZE  corrected fetch PC.
- stat_branches  out  16  resolved-branch count.
- stat_mispred  out  16  mispredict count.

Function
REQ-003 Lookup: combinational from lk_pc and current state, zero-cycle latency.
REQ-004 Index: bimodal idx = lk_pc[IDX-1:0]; gshare idx = lk_pc[IDX-1:0] XOR zero-extended GHR.
REQ-005 BTB entry: valid, tag = pc[WORD_SIZE-1:IDX], target; BTB is always indexed by lk_pc[IDX-1:0].
REQ-006 lk_hit = valid AND tag match. lk_taken = lk_is_branch AND lk_hit AND PHT[idx] MSB.
REQ-007 lk_next_pc = lk_taken ? BTB target : lk_pc+1, with modulo 2^WORD_SIZE wrap (0xFFFF+1 = 0x0000).
REQ-008 Checkpoint: on lk_fire AND lk_is_branch, register {lk_pc+1, lk_taken, PHT idx, GHR}. The checkpoint holds while lk_fire=0.
REQ-009 Speculative GHR: on lk_fire AND lk_is_branch, GHR <= {GHR[HIST_BITS-2:0], lk_taken}. GHR is absent when HIST_BITS=0.
REQ-010 Mispredict: up_mispredict = up_valid AND (up_taken != checkpointed prediction).
REQ-011 up_fix_pc = up_taken ? up_target : checkpointed pc+1.
REQ-012 On up_mispredict, GHR <= {checkpoint GHR shifted, up_taken}; this repair overrides a same-cycle speculative shift (wrong-path fetch).
REQ-013 On up_valid, PHT[checkpoint idx] saturates toward up_taken: +1 capped at 2^CNT_BITS-1, -1 floored at 0; no wrap.
REQ-014 On up_valid AND up_taken, BTB[up_pc[IDX-1:0]] <= {1, tag, up_target}. A not-taken resolution leaves the BTB unchanged.
REQ-015 Lookup and update in the same cycle on the same entry: lookup returns the pre-update value; the write lands at the clock edge.
REQ-016 An update resolves the most recent checkpointed branch; up_valid with no outstanding checkpoint is a protocol violation, and the design does not detect it.
REQ-017 stat_branches increments on up_valid; stat_mispred increments on up_mispredict; both saturate at 0xFFFF.

Reset
REQ-018 reset asserted clears state immediately, independent of clk, including mid-update:
- all BTB valid bits = 0;
- all PHT counters = 2^(CNT_BITS-1)-1 (weakly not-taken);
- GHR and checkpoint = 0;
- stats = 0.
REQ-019 While reset is high: lk_taken=0, lk_hit=0, lk_next_pc=lk_pc+1, up_mispredict=0; all state updates are suppressed.

Structure
REQ-020 Shared package bp_pkg holds the counter-init constant function, the mode encoding (BIMODAL/GSHARE), and the checkpoint record typedef.
REQ-021 One sub-module, sat_counter (parametrised width, inc/dec/enable, saturating), is instantiated per PHT entry or as the single update datapath.

Verification
REQ-022 Reset, then lookup lk_pc=0x0010, lk_is_branch=1 -> lk_hit=0, lk_taken=0, lk_next_pc=0x0011.
REQ-023 Bimodal, ENTRIES=16: branch at 0x0024 resolves taken twice to 0x0030 -> the third lookup gives lk_hit=1, lk_taken=1, lk_next_pc=0x0030, stat_branches=2.
REQ-024 Counter saturation: 5 taken resolutions then 1 not-taken -> counter 3→2, prediction stays taken; 3 more not-taken -> counter 0, held at 0.
REQ-025 Gshare, HIST_BITS=4: predicted taken, actual not-taken, same-cycle lk_fire on a wrong-path branch -> up_mispredict=1, up_fix_pc=pc+1, GHR = repaired value (speculative shift discarded), stat_mispred=1.
REQ-026 Aliasing: 0x0005 and 0x0015 both taken, with targets 0x0040 and 0x0050 -> lookup of 0x0005 gives lk_hit=0 (tag overwritten); 0x0015 gives 0x0050.
REQ-027 Reset pulsed asynchronously between clock edges during up_valid -> all state returns to reset values without waiting for clk; no BTB write occurs.
